wb_commit_unit: RTL and testbench
=================================

// Module: wb_commit_unit
// PURPOSE
//  Writeback commit unit: the writer that drives the single regfile write port (we/rd/wd).
//  Accepts results from the ALU and the LSU over valid/ready and holds one result per source.
//  Arbitrates one commit per cycle and keeps a 32-bit busy scoreboard for decode hazard checks.
// PARAMETERS
//  DATA_W  32  result / write-data width
//  ADDR_W  5   register index width (2**ADDR_W busy bits)
//  FAIR    1   1: round-robin ALU/LSU; 0: fixed priority, LSU always wins
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       async active-low reset
//  alu_valid  in   1       ALU result valid
//  alu_ready  out  1       ALU result accepted when valid&&ready at clk edge
//  alu_rd     in   ADDR_W  ALU destination register
//  alu_wd     in   DATA_W  ALU result
//  lsu_valid  in   1       load result valid
//  lsu_ready  out  1       load result accepted when valid&&ready
//  lsu_rd     in   ADDR_W  load destination register
//  lsu_wd     in   DATA_W  load data
//  iss_valid  in   1       decode issues an instruction that writes iss_rd
//  iss_rd     in   ADDR_W  destination of the issued instruction
//  chk_rs1    in   ADDR_W  decode source-1 index for hazard query
//  chk_rs2    in   ADDR_W  decode source-2 index for hazard query
//  hz_rs1     out  1       busy[chk_rs1] (combinational)
//  hz_rs2     out  1       busy[chk_rs2] (combinational)
//  hz_rd      out  1       busy[iss_rd] (WAW; decode must stall, not issue)
//  rf_we      out  1       regfile write enable (registered)
//  rf_rd      out  ADDR_W  regfile write index (registered)
//  rf_wd      out  DATA_W  regfile write data (registered)
// BEHAVIOUR
//  - Reset (async, rst_n=0): both hold regs empty, busy all 0, rf_we=0, rf_rd=0, rf_wd=0,
//    last_grant=ALU (first contested grant goes to LSU). Pending results are discarded.
//  - Hold regs: one entry per source. x_ready = !x_hold_v || x_grant (combinational), so a
//    source sustains 1 result/cycle when granted every cycle.
//  - Arbitration (comb, on hold regs only): one valid -> grant it; both valid -> FAIR=1 grants
//    the source not in last_grant, FAIR=0 grants LSU. last_grant updates only on a contested grant.
//  - Commit: at the edge a hold reg is granted, rf_we<=1, rf_rd<=hold_rd, rf_wd<=hold_wd; the hold
//    reg empties (or reloads if the same edge accepts new data). No grant -> rf_we<=0, rf_rd/rf_wd hold.
//  - Latency: accepted at edge k -> rf_we high in cycle after edge k+1 (uncontested) -> regfile
//    writes at edge k+2. Contested loser waits one extra cycle per lost grant.
//  - rd==0: accepted and granted normally, but rf_we stays 0; busy[0] never set.
//  - Scoreboard: iss_valid && iss_rd!=0 sets busy[iss_rd]; rf_we && rf_rd!=0 clears busy[rf_rd]
//    at the edge. Same index set and cleared in one edge -> set wins. hz_* read the current busy
//    vector; no bypass of the clear. Decode issues no writer while hz_rd=1 (one pending write/reg).
//  - Same-rd results from both sources in one cycle cannot occur given the hz_rd rule;
//    the arbiter does not check it.
//  - rf_wd/rf_rd only meaningful when rf_we=1.
// TESTING
//  1 Reset mid-traffic: both hold regs full, busy[5]=1, pull rst_n low between edges ->
//    rf_we=0, ready=1 immediately, busy=0, no write after release.
//  2 Single ALU: alu rd=3 wd=0xDEADBEEF at edge 0 -> rf_we=1,rf_rd=3,rf_wd=0xDEADBEEF after edge 1;
//    busy[3] set by issue earlier clears at edge 2.
//  3 Contention FAIR=1: both valid every cycle (ALU rd=1.., LSU rd=17..) -> commits alternate
//    LSU,ALU,LSU,...; each ready toggles accordingly; FAIR=0 -> LSU only, alu_ready=0 while held.
//  4 rd=0: alu rd=0 wd=0x1234 -> alu_ready handshake completes, rf_we stays 0, busy unchanged.
//  5 Set/clear collision: iss_valid rd=7 on the same edge rf_we commits rd=7 -> busy[7]=1 after,
//    hz_rs1=1 with chk_rs1=7.
//  6 Back-to-back single source: lsu_valid held 4 cycles rd=8..11 -> 4 commits on consecutive
//    cycles, lsu_ready never drops.

Source files
------------

// File: rtl/wb_commit_unit.sv
// Writeback commit unit: holds one ALU and one LSU result, commits one per cycle to the
// regfile write port, and tracks a per-register busy scoreboard for decode hazard checks.
`timescale 1ns/1ps
module wb_commit_unit #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned FAIR   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [DATA_W-1:0] alu_wd,
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic [ADDR_W-1:0] lsu_rd,
   input  logic [DATA_W-1:0] lsu_wd,
   input  logic              iss_valid,
   input  logic [ADDR_W-1:0] iss_rd,
   input  logic [ADDR_W-1:0] chk_rs1,
   input  logic [ADDR_W-1:0] chk_rs2,
   output logic              hz_rs1,
   output logic              hz_rs2,
   output logic              hz_rd,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_rd,
   output logic [DATA_W-1:0] rf_wd
);

   localparam int unsigned NREG = 1 << ADDR_W;

   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] wd;
   } res_t;

   logic            alu_hv;
   res_t            alu_h;
   logic            lsu_hv;
   res_t            lsu_h;
   logic            last_lsu;
   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_nxt_c;
   logic            alu_grant_c;
   logic            lsu_grant_c;
   logic            contested_c;

   // Arbiter: on a tie FAIR alternates away from the last contested winner, else LSU wins.
   always_comb begin
      contested_c = alu_hv && lsu_hv;
      lsu_grant_c = lsu_hv && (!alu_hv || (FAIR == 0) || !last_lsu);
      alu_grant_c = alu_hv && !lsu_grant_c;
   end

   assign alu_ready = !alu_hv || alu_grant_c;
   assign lsu_ready = !lsu_hv || lsu_grant_c;

   assign hz_rs1 = busy[chk_rs1];
   assign hz_rs2 = busy[chk_rs2];
   assign hz_rd  = busy[iss_rd];

   // Hold registers: a granted entry may be replaced by new data on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_hv <= 1'b0;
         alu_h  <= '0;
         lsu_hv <= 1'b0;
         lsu_h  <= '0;
      end else begin
         if (alu_valid && alu_ready) begin
            alu_hv <= 1'b1;
            alu_h  <= '{rd: alu_rd, wd: alu_wd};
         end else if (alu_grant_c) begin
            alu_hv <= 1'b0;
         end
         if (lsu_valid && lsu_ready) begin
            lsu_hv <= 1'b1;
            lsu_h  <= '{rd: lsu_rd, wd: lsu_wd};
         end else if (lsu_grant_c) begin
            lsu_hv <= 1'b0;
         end
      end
   end

   // Commit register: writes to x0 are consumed but never enable the regfile.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we    <= 1'b0;
         rf_rd    <= '0;
         rf_wd    <= '0;
         last_lsu <= 1'b0;
      end else begin
         if (alu_grant_c) begin
            rf_we <= (alu_h.rd != '0);
            rf_rd <= alu_h.rd;
            rf_wd <= alu_h.wd;
         end else if (lsu_grant_c) begin
            rf_we <= (lsu_h.rd != '0);
            rf_rd <= lsu_h.rd;
            rf_wd <= lsu_h.wd;
         end else begin
            rf_we <= 1'b0;
         end
         if (contested_c) begin
            last_lsu <= lsu_grant_c;
         end
      end
   end

   // Scoreboard: a new issue to a register wins over the clear of its retiring write.
   always_comb begin
      busy_nxt_c = busy;
      if (rf_we && (rf_rd != '0)) begin
         busy_nxt_c[rf_rd] = 1'b0;
      end
      if (iss_valid && (iss_rd != '0)) begin
         busy_nxt_c[iss_rd] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt_c;
      end
   end

endmodule

// File: tb/tb_wb_commit_unit.sv
// Bench for wb_commit_unit: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations on a FAIR=1 and a FAIR=0 instance.
`timescale 1ns/1ps
module tb_wb_commit_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        alu_valid, lsu_valid, iss_valid;
   logic [4:0]  alu_rd, lsu_rd, iss_rd, chk_rs1, chk_rs2;
   logic [31:0] alu_wd, lsu_wd;
   logic        alu_ready, lsu_ready, hz_rs1, hz_rs2, hz_rd, rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wd;

   logic        f_alu_valid, f_lsu_valid;
   logic [4:0]  f_alu_rd, f_lsu_rd;
   logic [31:0] f_alu_wd, f_lsu_wd;
   logic        f_alu_ready, f_lsu_ready, f_hz1, f_hz2, f_hzrd, f_rf_we;
   logic [4:0]  f_rf_rd;
   logic [31:0] f_rf_wd;

   int checks = 0;
   int errors = 0;
   bit started = 1'b0;

   always #5 clk = ~clk;

   wb_commit_unit #(.DATA_W(32), .ADDR_W(5), .FAIR(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_wd(alu_wd),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
      .hz_rs1(hz_rs1), .hz_rs2(hz_rs2), .hz_rd(hz_rd),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd)
   );

   wb_commit_unit #(.DATA_W(32), .ADDR_W(5), .FAIR(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(f_alu_valid), .alu_ready(f_alu_ready), .alu_rd(f_alu_rd), .alu_wd(f_alu_wd),
      .lsu_valid(f_lsu_valid), .lsu_ready(f_lsu_ready), .lsu_rd(f_lsu_rd), .lsu_wd(f_lsu_wd),
      .iss_valid(1'b0), .iss_rd(5'd0), .chk_rs1(5'd0), .chk_rs2(5'd0),
      .hz_rs1(f_hz1), .hz_rs2(f_hz2), .hz_rd(f_hzrd),
      .rf_we(f_rf_we), .rf_rd(f_rf_rd), .rf_wd(f_rf_wd)
   );

   task automatic cmp1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic cmpv(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference model: each source is a queue of at most one pending result.
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] wd;
   } res_t;

   res_t        aq[$];
   res_t        lq[$];
   bit          m_last_lsu;
   bit          busy_m[32];
   logic        m_we;
   logic [4:0]  m_rd;
   logic [31:0] m_wd;

   // 0 = nobody, 1 = ALU, 2 = LSU
   function automatic int pick();
      if (aq.size() == 0 && lq.size() == 0) return 0;
      if (lq.size() == 0) return 1;
      if (aq.size() == 0) return 2;
      return m_last_lsu ? 1 : 2;
   endfunction

   function automatic bit m_ready(input bit is_lsu);
      if (is_lsu) return (lq.size() == 0) || (pick() == 2);
      return (aq.size() == 0) || (pick() == 1);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aq.delete();
         lq.delete();
         m_last_lsu = 1'b0;
         foreach (busy_m[i]) busy_m[i] = 1'b0;
         m_we = 1'b0;
         m_rd = '0;
         m_wd = '0;
      end else begin
         int   g;
         bit   acc_a, acc_l;
         res_t e;
         g     = pick();
         acc_a = alu_valid && m_ready(1'b0);
         acc_l = lsu_valid && m_ready(1'b1);
         if (m_we && m_rd != 0) busy_m[m_rd] = 1'b0;
         if (iss_valid && iss_rd != 0) busy_m[iss_rd] = 1'b1;
         if (aq.size() > 0 && lq.size() > 0) m_last_lsu = (g == 2);
         e = '{rd: 5'd0, wd: 32'd0};
         if (g == 1) e = aq.pop_front();
         else if (g == 2) e = lq.pop_front();
         if (g != 0) begin
            m_we = (e.rd != 0);
            m_rd = e.rd;
            m_wd = e.wd;
         end else begin
            m_we = 1'b0;
         end
         if (acc_a) aq.push_back('{rd: alu_rd, wd: alu_wd});
         if (acc_l) lq.push_back('{rd: lsu_rd, wd: lsu_wd});
      end
   end

   always @(negedge clk) begin
      if (rst_n && started) begin
         cmp1("m_rf_we", rf_we, m_we);
         if (m_we) begin
            cmpv("m_rf_rd", 32'(rf_rd), 32'(m_rd));
            cmpv("m_rf_wd", rf_wd, m_wd);
         end
         cmp1("m_alu_ready", alu_ready, m_ready(1'b0));
         cmp1("m_lsu_ready", lsu_ready, m_ready(1'b1));
         cmp1("m_hz_rs1", hz_rs1, busy_m[chk_rs1]);
         cmp1("m_hz_rs2", hz_rs2, busy_m[chk_rs2]);
         cmp1("m_hz_rd", hz_rd, busy_m[iss_rd]);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int   a, l;
      bit   ra, rl;
      int   log_q[$];
      int   exp3[6];
      exp3 = '{17, 1, 18, 2, 19, 3};
      alu_valid = 0; alu_rd = 0; alu_wd = 0;
      lsu_valid = 0; lsu_rd = 0; lsu_wd = 0;
      iss_valid = 0; iss_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
      f_alu_valid = 0; f_alu_rd = 0; f_alu_wd = 0;
      f_lsu_valid = 0; f_lsu_rd = 0; f_lsu_wd = 0;

      // reset values
      #3;
      cmp1("rst_rf_we", rf_we, 1'b0);
      cmp1("rst_alu_ready", alu_ready, 1'b1);
      cmp1("rst_lsu_ready", lsu_ready, 1'b1);
      cmpv("rst_rf_rd", 32'(rf_rd), 32'd0);
      cmpv("rst_rf_wd", rf_wd, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      started = 1'b1;

      // single ALU result, busy[3] cleared at the regfile write edge
      iss_valid = 1; iss_rd = 5'd3;
      cyc();
      iss_valid = 0;
      alu_valid = 1; alu_rd = 5'd3; alu_wd = 32'hDEADBEEF; chk_rs1 = 5'd3;
      #1;
      cmp1("t2_hz_before", hz_rs1, 1'b1);
      cmp1("t2_alu_ready", alu_ready, 1'b1);
      cyc();
      alu_valid = 0;
      cmp1("t2_no_we_yet", rf_we, 1'b0);
      cyc();
      cmp1("t2_we", rf_we, 1'b1);
      cmpv("t2_rd", 32'(rf_rd), 32'd3);
      cmpv("t2_wd", rf_wd, 32'hDEADBEEF);
      cmp1("t2_hz_still", hz_rs1, 1'b1);
      cyc();
      cmp1("t2_we_drop", rf_we, 1'b0);
      cmp1("t2_hz_clear", hz_rs1, 1'b0);

      // rd = 0 consumed without a regfile write
      alu_valid = 1; alu_rd = 5'd0; alu_wd = 32'h1234; chk_rs2 = 5'd0;
      #1;
      cmp1("t4_ready", alu_ready, 1'b1);
      cyc();
      alu_valid = 0;
      cyc();
      cmp1("t4_we0_a", rf_we, 1'b0);
      cmp1("t4_alu_ready_after", alu_ready, 1'b1);
      cyc();
      cmp1("t4_we0_b", rf_we, 1'b0);
      cmp1("t4_hz0", hz_rs2, 1'b0);

      // set and clear of busy[7] on the same edge
      iss_valid = 1; iss_rd = 5'd7;
      cyc();
      iss_valid = 0;
      alu_valid = 1; alu_rd = 5'd7; alu_wd = 32'h0000_0777;
      cyc();
      alu_valid = 0;
      cyc();
      cmp1("t5_we", rf_we, 1'b1);
      cmpv("t5_rd", 32'(rf_rd), 32'd7);
      iss_valid = 1; iss_rd = 5'd7;
      #1;
      cmp1("t5_hz_rd", hz_rd, 1'b1);
      cyc();
      iss_valid = 0; chk_rs1 = 5'd7;
      #1;
      cmp1("t5_busy_kept", hz_rs1, 1'b1);

      // back-to-back LSU results rd=8..11
      lsu_valid = 1; lsu_rd = 5'd8; lsu_wd = 32'hB000_0008;
      for (int i = 0; i < 4; i++) begin
         #1;
         cmp1("t6_lsu_ready", lsu_ready, 1'b1);
         cyc();
         if (i >= 1) begin
            cmp1("t6_we", rf_we, 1'b1);
            cmpv("t6_rd", 32'(rf_rd), 32'(8 + i - 1));
         end
         if (i < 3) begin
            lsu_rd = 5'(9 + i);
            lsu_wd = 32'hB000_0000 | 32'(9 + i);
         end else begin
            lsu_valid = 0;
         end
      end
      cyc();
      cmp1("t6_we_last", rf_we, 1'b1);
      cmpv("t6_rd_last", 32'(rf_rd), 32'd11);
      cmpv("t6_wd_last", rf_wd, 32'hB000_000B);
      cyc();
      cmp1("t6_we_end", rf_we, 1'b0);

      // contention, round-robin
      a = 1; l = 17;
      alu_valid = 1; alu_rd = 5'(a); alu_wd = 32'hA000_0000 | 32'(a);
      lsu_valid = 1; lsu_rd = 5'(l); lsu_wd = 32'hB000_0000 | 32'(l);
      for (int c = 0; c < 10; c++) begin
         #1;
         ra = alu_ready;
         rl = lsu_ready;
         cyc();
         if (rf_we) log_q.push_back(int'(rf_rd));
         if (ra) a++;
         if (rl) l++;
         alu_rd = 5'(a); alu_wd = 32'hA000_0000 | 32'(a);
         lsu_rd = 5'(l); lsu_wd = 32'hB000_0000 | 32'(l);
      end
      alu_valid = 0; lsu_valid = 0;
      for (int c = 0; c < 3; c++) begin
         cyc();
         if (rf_we) log_q.push_back(int'(rf_rd));
      end
      for (int i = 0; i < 6; i++) begin
         cmpv("t3_order", (i < log_q.size()) ? 32'(log_q[i]) : 32'hFFFF_FFFF, 32'(exp3[i]));
      end

      // reset with both hold registers full and busy[5] set
      iss_valid = 1; iss_rd = 5'd5;
      cyc();
      iss_valid = 0;
      alu_valid = 1; alu_rd = 5'd12; alu_wd = 32'hA000_000C;
      lsu_valid = 1; lsu_rd = 5'd13; lsu_wd = 32'hB000_000D;
      cyc();
      alu_rd = 5'd14; alu_wd = 32'hA000_000E;
      lsu_rd = 5'd15; lsu_wd = 32'hB000_000F;
      cyc();
      alu_valid = 0; lsu_valid = 0; chk_rs1 = 5'd5;
      #1;
      cmp1("t1_pre_we", rf_we, 1'b1);
      cmp1("t1_pre_busy", hz_rs1, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      cmp1("t1_we", rf_we, 1'b0);
      cmp1("t1_alu_ready", alu_ready, 1'b1);
      cmp1("t1_lsu_ready", lsu_ready, 1'b1);
      cmp1("t1_busy", hz_rs1, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         cyc();
         cmp1("t1_no_write", rf_we, 1'b0);
      end
      cmp1("t1_busy_after", hz_rs1, 1'b0);

      // fixed priority instance: LSU always wins
      f_alu_valid = 1; f_alu_rd = 5'd1; f_alu_wd = 32'hA000_0001;
      f_lsu_valid = 1; f_lsu_rd = 5'd17; f_lsu_wd = 32'hB000_0011;
      cyc();
      f_alu_valid = 0;
      for (int k = 18; k <= 20; k++) begin
         f_lsu_rd = 5'(k);
         f_lsu_wd = 32'hB000_0000 | 32'(k);
         #1;
         cmp1("f0_alu_held", f_alu_ready, 1'b0);
         cmp1("f0_lsu_ready", f_lsu_ready, 1'b1);
         cyc();
         cmp1("f0_we", f_rf_we, 1'b1);
         cmpv("f0_rd", 32'(f_rf_rd), 32'(k - 1));
      end
      f_lsu_valid = 0;
      #1;
      cmp1("f0_alu_held_last", f_alu_ready, 1'b0);
      cyc();
      cmpv("f0_rd20", 32'(f_rf_rd), 32'd20);
      cmp1("f0_alu_ready", f_alu_ready, 1'b1);
      cyc();
      cmp1("f0_alu_we", f_rf_we, 1'b1);
      cmpv("f0_alu_rd", 32'(f_rf_rd), 32'd1);
      cmpv("f0_alu_wd", f_rf_wd, 32'hA000_0001);
      cyc();
      cmp1("f0_idle", f_rf_we, 1'b0);
      cmp1("f0_hz", f_hz1 | f_hz2 | f_hzrd, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
